// File: rtl/stochastic_alu_param.sv
// Stochastic-computing ALU: serially loads two operands, runs them as LFSR-compared
// bitstreams through a mode-selected gate and counts ones over a 2^WIN_LOG2 window.
// Optional macro STOCH_CONTINUOUS_EN: DONE re-enters RUN with the same operands
// instead of returning to IDLE.
module stochastic_alu_param #(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned WIN_LOG2 = 17,
    parameter logic [30:0] SEED     = 31'd134995
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ser_a,
    input  logic             ser_b,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic [WIDTH:0]   result,
    output logic             result_valid
);

    localparam int unsigned CNT_W = WIN_LOG2 + 1;
    localparam int unsigned SHIFT = WIN_LOG2 - WIDTH;
    localparam int unsigned BIT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [30:0]          lfsr;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [1:0]           mode_q;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WIN_LOG2-1:0]  win_cnt;
    logic [CNT_W-1:0]     ones_cnt;

    logic sa_c;
    logic sb_c;
    logic sel_c;
    logic s_c;

    // Stream generation: operand vs. pseudo-random slice of the LFSR
    always_comb begin
        sa_c  = lfsr[WIDTH-1:0] < op_a;
        sb_c  = lfsr[30:31-WIDTH] < op_b;
        sel_c = lfsr[15];
        unique case (mode_q)
            2'b00:   s_c = ~(sa_c ^ sb_c);
            2'b01:   s_c = sel_c ? sb_c : sa_c;
            2'b10:   s_c = sa_c & sb_c;
            default: s_c = sa_c | sb_c;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (bit_cnt == BIT_W'(WIDTH - 1)) state_next = RUN;
            RUN:  if (win_cnt == '1) state_next = DONE;
            DONE: begin
`ifdef STOCH_CONTINUOUS_EN
                state_next = start ? LOAD : RUN;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr         <= SEED;
            op_a         <= '0;
            op_b         <= '0;
            mode_q       <= 2'b00;
            bit_cnt      <= '0;
            win_cnt      <= '0;
            ones_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            lfsr         <= {lfsr[29:0], lfsr[27] ^ lfsr[30]};
            busy         <= (state_next != IDLE);
            result_valid <= (state == DONE);

            if (state == DONE)
                result <= (WIDTH + 1)'(ones_cnt >> SHIFT);

            // Mode is captured only when a new load begins
            if (state_next == LOAD && state != LOAD) begin
                mode_q  <= mode;
                bit_cnt <= '0;
            end else if (state == LOAD) begin
                op_a    <= {op_a[WIDTH-2:0], ser_a};
                op_b    <= {op_b[WIDTH-2:0], ser_b};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state_next == RUN && state != RUN) begin
                win_cnt  <= '0;
                ones_cnt <= '0;
            end else if (state == RUN) begin
                win_cnt  <= win_cnt + WIN_LOG2'(1);
                ones_cnt <= ones_cnt + CNT_W'(s_c);
            end
        end
    end

endmodule

// File: tb/tb_stochastic_alu_param.sv
// Directed self-checking bench for stochastic_alu_param (WIDTH=9, WIN_LOG2=10).
module tb_stochastic_alu_param;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       ser_a;
    logic       ser_b;
    logic [1:0] mode;
    logic       busy;
    logic [9:0] result;
    logic       result_valid;

    int checks = 0;
    int errors = 0;

    stochastic_alu_param #(
        .WIDTH   (9),
        .WIN_LOG2(10),
        .SEED    (31'd134995)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ser_a       (ser_a),
        .ser_b       (ser_b),
        .mode        (mode),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reset, fixed-phase start, serial load, then watch for the result pulse
    task automatic do_run(input logic [1:0] m, input logic [8:0] a, input logic [8:0] b,
                          input bit disturb, output int lat, output int pulses,
                          output int res, output int busy_mid, output int busy_after);
        int cnt;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) mode = ~m;
        for (int i = 8; i >= 0; i--) begin
            ser_a = a[i];
            ser_b = b[i];
            if (disturb && i == 4) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        cnt = 9; pulses = 0; lat = -1; res = -1; busy_mid = -1; busy_after = -1;
        while (cnt < 1200) begin
            if (disturb) ser_a = ~ser_a;
            if (disturb && cnt == 500) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
            if (cnt == 600) busy_mid = int'(busy);
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat        = cnt;
                    res        = int'(result);
                    busy_after = int'(busy);
                end
            end
        end
        mode = 2'b00;
    endtask

    int lat, pulses, res, busy_mid, busy_after, ref_res, n;

    initial begin
        rst_n = 1'b1; start = 1'b0; ser_a = 1'b0; ser_b = 1'b0; mode = 2'b00;
        @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(result_valid), 0);

        do_run(2'b00, 9'd0, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m00_latency", lat, 1034);
        check("m00_result", res, 512);
        check("m00_msb", (res >> 9) & 1, 1);
        check("m00_busy_run", busy_mid, 1);
`ifdef STOCH_CONTINUOUS_EN
        check("m00_busy_done", busy_after, 1);
`else
        check("m00_pulses", pulses, 1);
        check("m00_busy_done", busy_after, 0);
`endif

        do_run(2'b01, 9'd0, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m01_zero", res, 0);
        do_run(2'b10, 9'd0, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m10_zero", res, 0);
        do_run(2'b11, 9'd0, 9'd256, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m11_half_in_range", int'(res >= 232 && res <= 280), 1);
        do_run(2'b00, 9'd256, 9'd256, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m00_half_in_range", int'(res >= 232 && res <= 280), 1);
        do_run(2'b11, 9'd511, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        check("m11_amax_in_range", int'(res >= 500 && res <= 512), 1);

        do_run(2'b10, 9'd256, 9'd256, 1'b0, lat, pulses, ref_res, busy_mid, busy_after);
        check("m10_quarter_in_range", int'(ref_res >= 108 && ref_res <= 148), 1);
        do_run(2'b10, 9'd256, 9'd256, 1'b1, lat, pulses, res, busy_mid, busy_after);
        check("disturb_result", res, ref_res);
        check("disturb_pulses", pulses, 1);
        check("disturb_latency", lat, 1034);

`ifdef STOCH_CONTINUOUS_EN
        do_run(2'b00, 9'd0, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        n = 0;
        while (!result_valid && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        check("cont_first_found", int'(result_valid), 1);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
                if (!result_valid) check("cont_busy_held", int'(busy), 1);
            end while (!result_valid && n < 1100);
            check("cont_period", n, 1025);
            check("cont_result", int'(result), 512);
        end
`endif

        // Asynchronous reset in the middle of RUN
        do_run(2'b00, 9'd0, 9'd0, 1'b0, lat, pulses, res, busy_mid, busy_after);
        mode = 2'b00; ser_a = 1'b0; ser_b = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("midrun_busy", int'(busy), 1);
        check("midrun_result_held", int'(result), 512);
        #2 rst_n = 1'b1;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_result", int'(result), 0);
        check("async_valid", int'(result_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        pulses = 0;
        repeat (1200) begin
            @(posedge clk); #1;
            if (result_valid) pulses++;
        end
        check("post_reset_pulses", pulses, 0);
        check("post_reset_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
